ysyx_24100006_icache_flush_ctrl: RTL and testbench

//   Sequences the icache invalidation for fence.i. The EXE stage raises flush_req on entering
//   its flush-wait state. This block holds IFU fetch, waits out any in-flight refill, then

---
 rtl/ysyx_24100006_icache_flush_ctrl.sv | 117 +++++++++++
 tb/tb_ysyx_24100006_icache_flush_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100006_icache_flush_ctrl.sv
// Purpose: sequences the fence.i icache invalidation (hold fetch, drain refill, sweep the sets, pulse done).
// Latency: with the icache idle, the sets are cleared in cycles 1..NSETS after the flush_req rising edge, and flush_done pulses at NSETS+1 (fast build: clear at 1, done at 2).
// Backpressure: i_icache_busy stalls the start of the sweep in WAIT. A request arriving while a flush is running is dropped.
//
// Optional build macro: ICACHE_FLUSH_FAST_EN
//   Defined   -> a single bulk-clear cycle (o_inv_all), and no set index counter.
//   Undefined -> one set per cycle via o_inv_en/o_inv_idx, with o_inv_all tied 0.
//
// Ports:
//   i_clk          clock; all state updates on posedge
//   i_reset        synchronous, active-high reset
//   i_flush_req    level from EXE; only its rising edge starts a flush
//   i_icache_busy  refill/AXI burst in flight; the sweep must not begin while high
//   o_fetch_hold   blocks IFU lookups/refills for the whole flush, DONE included
//   o_flush_busy   any non-IDLE state
//   o_inv_en       clear all ways' valid bits in set o_inv_idx this cycle
//   o_inv_idx      set being invalidated (0 outside SWEEP)
//   o_inv_all      bulk-clear of all valid bits (fast build only)
//   o_flush_done   one-cycle completion pulse to EXE
module ysyx_24100006_icache_flush_ctrl #(
    parameter int NSETS = 16,
    parameter int IDX_W = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_flush_req,
    input  logic             i_icache_busy,
    output logic             o_fetch_hold,
    output logic             o_flush_busy,
    output logic             o_inv_en,
    output logic [IDX_W-1:0] o_inv_idx,
    output logic             o_inv_all,
    output logic             o_flush_done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_SWEEP = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0] r_state;
    logic       r_req_q;
    logic       w_start;

    // Only a rising edge starts a flush. A request held high across
    // DONE->IDLE therefore does not retrigger.
    assign w_start = i_flush_req & ~r_req_q;

`ifdef ICACHE_FLUSH_FAST_EN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_req_q <= 1'b0;
        end else begin
            r_req_q <= i_flush_req;
            case (r_state)
                S_IDLE:  if (w_start) r_state <= i_icache_busy ? S_WAIT : S_SWEEP;
                S_WAIT:  if (!i_icache_busy) r_state <= S_SWEEP;
                S_SWEEP: r_state <= S_DONE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_inv_en  = 1'b0;
    assign o_inv_idx = '0;
    assign o_inv_all = (r_state == S_SWEEP);
`else
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSETS - 1);

    logic [IDX_W-1:0] r_idx;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_req_q <= 1'b0;
            r_idx   <= '0;
        end else begin
            r_req_q <= i_flush_req;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= i_icache_busy ? S_WAIT : S_SWEEP;
                        r_idx   <= '0;
                    end
                end
                S_WAIT:  if (!i_icache_busy) r_state <= S_SWEEP;
                S_SWEEP: begin
                    // Stop on the last set instead of wrapping, so that r_idx
                    // never leaves the range 0..NSETS-1.
                    if (r_idx == LAST_IDX) r_state <= S_DONE;
                    else                   r_idx   <= r_idx + 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_inv_en  = (r_state == S_SWEEP);
    assign o_inv_idx = (r_state == S_SWEEP) ? r_idx : '0;
    assign o_inv_all = 1'b0;
`endif

    // The outputs are decoded purely from the registered state. Hold stays
    // high through DONE, so the first fetch after a flush sees invalid sets.
    assign o_fetch_hold = (r_state != S_IDLE);
    assign o_flush_busy = (r_state != S_IDLE);
    assign o_flush_done = (r_state == S_DONE);

`ifndef SYNTHESIS
    // A refill starting mid-sweep is a protocol violation by the fetch side.
    // The sweep ignores it.
    a_no_busy_in_sweep: assert property (@(posedge i_clk) disable iff (i_reset)
        (r_state == S_SWEEP) |-> !$rose(i_icache_busy));
`endif

endmodule

// File: tb/tb_ysyx_24100006_icache_flush_ctrl.sv
module tb_ysyx_24100006_icache_flush_ctrl;
    localparam int NSETS = 16;
    localparam int IDX_W = 4;
`ifdef ICACHE_FLUSH_FAST_EN
    localparam int NSW = 1;
`else
    localparam int NSW = NSETS;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             req;
    logic             busy;
    logic             hold;
    logic             fbusy;
    logic             inv_en;
    logic [IDX_W-1:0] inv_idx;
    logic             inv_all;
    logic             done;

    int n_assert = 0;
    int n_fail   = 0;

    ysyx_24100006_icache_flush_ctrl #(.NSETS(NSETS), .IDX_W(IDX_W)) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_flush_req   (req),
        .i_icache_busy (busy),
        .o_fetch_hold  (hold),
        .o_flush_busy  (fbusy),
        .o_inv_en      (inv_en),
        .o_inv_idx     (inv_idx),
        .o_inv_all     (inv_all),
        .o_flush_done  (done)
    );

    always #5 clk = ~clk;

    // Packed expectation: {hold, flush_busy, inv_en, inv_all, flush_done, inv_idx}
    localparam logic [8:0] IDLE_V = 9'b00000_0000;
    localparam logic [8:0] WAIT_V = 9'b11000_0000;
    localparam logic [8:0] DONE_V = 9'b11001_0000;

    // Advance one clock and settle away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [8:0] exp);
        logic [8:0] obs;
        obs = {hold, fbusy, inv_en, inv_all, done, inv_idx};
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_sweep(input string tag, input int k);
`ifdef ICACHE_FLUSH_FAST_EN
        chk(tag, {5'b11010, 4'd0});
`else
        chk(tag, {5'b11100, 4'(k)});
`endif
    endtask

    // Called in the first cycle after the sweep starts. It returns in the
    // IDLE cycle that follows DONE.
    task automatic run_flush(input string tag);
        for (int k = 0; k < NSW; k++) begin
            check_sweep({tag, "_sweep"}, k);
            tick();
        end
        chk({tag, "_done"}, DONE_V);
        tick();
        chk({tag, "_idle_after"}, IDLE_V);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        req   = 1'b0;
        busy  = 1'b0;
        tick();
        tick();
        chk("reset_state", IDLE_V);
        reset = 1'b0;
        tick();
        chk("idle_after_reset", IDLE_V);

        // T1: basic flush, icache idle
        req = 1'b1;
        tick();
        run_flush("t1");
        req = 1'b0;
        tick();
        chk("t1_idle2", IDLE_V);

        // T2: busy during cycles 0..4 -> WAIT in cycles 1..5
        req  = 1'b1;
        busy = 1'b1;
        tick();
        for (int c = 1; c <= 5; c++) begin
            chk("t2_wait", WAIT_V);
            if (c == 5) busy = 1'b0;
            tick();
        end
        run_flush("t2");
        req = 1'b0;
        tick();

        // T3: request held high -> a single flush, then a re-toggle gives a second one
        req = 1'b1;
        tick();
        run_flush("t3a");
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("t3_no_retrigger", IDLE_V);
        end
        req = 1'b0;
        tick();
        chk("t3_drop", IDLE_V);
        req = 1'b1;
        tick();
        run_flush("t3b");
        req = 1'b0;
        tick();

        // T4: reset in the middle of the sweep
        req = 1'b1;
        tick();
        for (int k = 0; k < ((NSW > 8) ? 8 : NSW); k++) begin
            check_sweep("t4_partial", k);
            if (k == ((NSW > 8) ? 7 : NSW - 1)) begin
                reset = 1'b1;
                req   = 1'b0;
            end
            tick();
        end
        chk("t4_reset_outputs", IDLE_V);
        reset = 1'b0;
        tick();
        chk("t4_no_done", IDLE_V);
        tick();
        chk("t4_still_idle", IDLE_V);
        req = 1'b1;
        tick();
        run_flush("t4_restart");
        req = 1'b0;
        tick();

        // T5: toggling the request during the sweep is ignored
        req = 1'b1;
        tick();
        for (int k = 0; k < NSW; k++) begin
            check_sweep("t5_sweep", k);
            req = ~req;
            tick();
        end
        req = 1'b0;
        chk("t5_done", DONE_V);
        tick();
        for (int c = 0; c < 4; c++) begin
            chk("t5_single_done", IDLE_V);
            tick();
        end

        // A falling request mid-flush does not abort the flush.
        req = 1'b1;
        tick();
        req = 1'b0;
        run_flush("fall_no_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
